// File: rtl/blake_nonce_sched.sv
// Nonce-sweep scheduler for a single blake core: issues one hash per nonce over
// an inclusive (possibly wrapping) range and reports the first digest at or below the target.
module blake_nonce_sched #(
  parameter bit STOP_ON_HIT = 1'b1
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         start,
  input  logic         stop,
  input  logic [607:0] header,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [63:0]  target,
  output logic         core_ena,
  output logic [639:0] core_din,
  input  logic [511:0] core_dout,
  input  logic         core_rdy,
  output logic         busy,
  output logic         done,
  output logic         hit,
  output logic         aborted,
  output logic [31:0]  found_nonce,
  output logic [511:0] found_hash,
  output logic [32:0]  hash_count
);

  // DRAIN is kept only as an encoding; an outstanding core_rdy at stop is served from WAIT.
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;

  state_t         state;
  logic [607:0]   hdr_q;
  logic [31:0]    nonce_q;
  logic [31:0]    end_q;
  logic [63:0]    tgt_q;
  logic           stop_pend;

  logic           is_hit;
  logic           last;
  logic           stop_seen;
  logic           hit_end;

  assign is_hit    = core_dout[511:448] <= tgt_q;
  assign last      = nonce_q == end_q;
  assign stop_seen = stop_pend | stop;
  assign hit_end   = STOP_ON_HIT && is_hit;
  assign core_din  = {hdr_q, nonce_q};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      hdr_q       <= '0;
      nonce_q     <= '0;
      end_q       <= '0;
      tgt_q       <= '0;
      stop_pend   <= 1'b0;
      core_ena    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hit         <= 1'b0;
      aborted     <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      hash_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A stop arriving alongside start is intentionally not captured.
          if (start) begin
            hdr_q       <= header;
            nonce_q     <= nonce_start;
            end_q       <= nonce_end;
            tgt_q       <= target;
            stop_pend   <= 1'b0;
            hit         <= 1'b0;
            aborted     <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            hash_count  <= '0;
            busy        <= 1'b1;
            core_ena    <= 1'b1;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          core_ena <= 1'b0;
          if (stop) stop_pend <= 1'b1;
          state <= WAIT;
        end

        WAIT: begin
          if (stop) stop_pend <= 1'b1;
          if (core_rdy) begin
            hash_count <= hash_count + 33'd1;
            if (is_hit && !hit) begin
              hit         <= 1'b1;
              found_nonce <= nonce_q;
              found_hash  <= core_dout;
            end
            // The in-flight hash is always evaluated before a stop takes effect.
            if (last || hit_end || stop_seen) begin
              aborted <= stop_seen && !last && !hit_end;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              nonce_q  <= nonce_q + 32'd1;
              core_ena <= 1'b1;
              state    <= ISSUE;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          core_ena <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blake_nonce_sched.sv
// Bench for blake_nonce_sched: two instances (STOP_ON_HIT=1 and 0) each driven by a
// fixed-latency model core; table vectors, hand sequences and random jobs vs a reference model.
module tb_blake_nonce_sched;

  typedef struct {
    bit          dut;
    logic [31:0] ns;
    logic [31:0] ne;
    logic [63:0] tgt;
    int          stop_hash;
    int          stop_cyc;
    bit          start_stop;
    bit          poke_start;
    bit          exp_hit;
    logic [31:0] exp_fn;
    logic [32:0] exp_cnt;
    bit          exp_ab;
  } vec_t;

  logic                clk;
  logic                rstb;
  logic [1:0]          start_w;
  logic [1:0]          stop_w;
  logic [607:0]        header;
  logic [31:0]         nonce_start;
  logic [31:0]         nonce_end;
  logic [63:0]         target;
  logic [1:0]          core_ena_w;
  logic [1:0][639:0]   core_din_w;
  logic [1:0][511:0]   core_dout_w;
  logic [1:0]          core_rdy_w;
  logic [1:0]          busy_w;
  logic [1:0]          done_w;
  logic [1:0]          hit_w;
  logic [1:0]          aborted_w;
  logic [1:0][31:0]    found_nonce_w;
  logic [1:0][511:0]   found_hash_w;
  logic [1:0][32:0]    hash_count_w;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  bit          act;
  logic [31:0] issued_q[$];
  logic [31:0] hold_nonce;
  int          mon_last_ena;
  int          mon_done;
  int          spacing_err;
  int          stab_err;
  int          hdr_err;

  blake_nonce_sched #(.STOP_ON_HIT(1'b1)) dut0 (
    .clk(clk), .rstb(rstb), .start(start_w[0]), .stop(stop_w[0]),
    .header(header), .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .core_ena(core_ena_w[0]), .core_din(core_din_w[0]), .core_dout(core_dout_w[0]),
    .core_rdy(core_rdy_w[0]), .busy(busy_w[0]), .done(done_w[0]), .hit(hit_w[0]),
    .aborted(aborted_w[0]), .found_nonce(found_nonce_w[0]), .found_hash(found_hash_w[0]),
    .hash_count(hash_count_w[0])
  );

  blake_nonce_sched #(.STOP_ON_HIT(1'b0)) dut1 (
    .clk(clk), .rstb(rstb), .start(start_w[1]), .stop(stop_w[1]),
    .header(header), .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .core_ena(core_ena_w[1]), .core_din(core_din_w[1]), .core_dout(core_dout_w[1]),
    .core_rdy(core_rdy_w[1]), .busy(busy_w[1]), .done(done_w[1]), .hit(hit_w[1]),
    .aborted(aborted_w[1]), .found_nonce(found_nonce_w[1]), .found_hash(found_hash_w[1]),
    .hash_count(hash_count_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Test core: latency 5 from core_ena to core_rdy, digest = {~nonce, 480'h0}.
  int          ccnt[2];
  logic [31:0] clat[2];
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int g = 0; g < 2; g++) begin
        ccnt[g] <= 0;
        clat[g] <= '0;
        core_rdy_w[g] <= 1'b0;
        core_dout_w[g] <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        core_rdy_w[g] <= 1'b0;
        if (core_ena_w[g]) begin
          ccnt[g] <= 1;
          clat[g] <= core_din_w[g][31:0];
        end else if (ccnt[g] == 4) begin
          ccnt[g] <= 0;
          core_rdy_w[g] <= 1'b1;
          core_dout_w[g] <= {~clat[g], 480'h0};
        end else if (ccnt[g] != 0) begin
          ccnt[g] <= ccnt[g] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstb) begin
      if (core_ena_w[act]) begin
        issued_q.push_back(core_din_w[act][31:0]);
        if (mon_last_ena >= 0 && cyc - mon_last_ena != 6) spacing_err++;
        mon_last_ena = cyc;
        if (core_din_w[act][639:32] !== header) hdr_err++;
        hold_nonce = core_din_w[act][31:0];
      end
      if (core_rdy_w[act] && core_din_w[act][31:0] !== hold_nonce) stab_err++;
      if (done_w[act]) mon_done++;
    end
  end

  task automatic checkOutput(input string name, input logic [639:0] actual, input logic [639:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(bit dut, logic [31:0] ns, logic [31:0] ne, logic [63:0] tgt,
                              int sh, int sc, bit ss, bit ps,
                              bit eh, logic [31:0] efn, logic [32:0] ecnt, bit eab);
    vec_t v;
    v.dut = dut; v.ns = ns; v.ne = ne; v.tgt = tgt;
    v.stop_hash = sh; v.stop_cyc = sc; v.start_stop = ss; v.poke_start = ps;
    v.exp_hit = eh; v.exp_fn = efn; v.exp_cnt = ecnt; v.exp_ab = eab;
    return v;
  endfunction

  // Walks the nonce list directly: each hash either hits, is the last, or sees the stop.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r = v;
    logic [31:0] n = v.ns;
    int cnt = 0;
    bit soh = (v.dut == 1'b0);
    r.exp_hit = 1'b0; r.exp_fn = '0; r.exp_ab = 1'b0;
    for (int guard = 0; guard < 1000; guard++) begin
      bit ih, lst, he, se;
      cnt++;
      ih = ({~n, 32'h0} <= v.tgt);
      if (ih && !r.exp_hit) begin r.exp_hit = 1'b1; r.exp_fn = n; end
      lst = (n == v.ne);
      he  = soh && ih;
      se  = (v.stop_hash != 0) && (cnt == v.stop_hash);
      if (lst || he || se) begin
        r.exp_ab = se && !lst && !he;
        break;
      end
      n = n + 32'd1;
    end
    r.exp_cnt = 33'(cnt);
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v, output bit timed_out);
    bit d = v.dut;
    int enas = 0;
    int pos = 0;
    int guard = 0;
    bit seen_done = 1'b0;
    @(negedge clk);
    act = d;
    for (int i = 0; i < 19; i++) header[i*32 +: 32] = $urandom;
    nonce_start = v.ns; nonce_end = v.ne; target = v.tgt;
    issued_q.delete();
    mon_last_ena = -1; mon_done = 0; spacing_err = 0; stab_err = 0; hdr_err = 0;
    if (v.start_stop) begin
      stop_w[d] = 1'b1;
      @(negedge clk);
    end
    start_w[d] = 1'b1;
    @(negedge clk);
    start_w[d] = 1'b0;
    stop_w[d] = 1'b0;
    checkOutput("start_to_ena", 640'({busy_w[d], core_ena_w[d]}), 640'(2'b11));
    while (!seen_done && guard < 400) begin
      if (core_ena_w[d]) begin enas++; pos = 1; end
      else if (pos > 0) pos++;
      stop_w[d]  = (enas == v.stop_hash) && (pos == v.stop_cyc);
      start_w[d] = v.poke_start && enas == 2 && pos == 3;
      nonce_start = start_w[d] ? ~v.ns : v.ns;
      if (done_w[d]) seen_done = 1'b1;
      else begin
        @(negedge clk);
        guard++;
      end
    end
    stop_w[d] = 1'b0;
    start_w[d] = 1'b0;
    nonce_start = v.ns;
    timed_out = !seen_done;
    if (seen_done) begin
      @(negedge clk);
      checkOutput("done_width", 640'(done_w[d]), 640'(0));
      checkOutput("busy_fall", 640'(busy_w[d]), 640'(0));
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_and_check(input vec_t v, input string tag);
    bit to;
    bit d = v.dut;
    int bad = 0;
    applyStimulus(v, to);
    checkOutput({tag, ".timeout"}, 640'(to), 640'(0));
    checkOutput({tag, ".hit"}, 640'(hit_w[d]), 640'(v.exp_hit));
    checkOutput({tag, ".aborted"}, 640'(aborted_w[d]), 640'(v.exp_ab));
    checkOutput({tag, ".found_nonce"}, 640'(found_nonce_w[d]), 640'(v.exp_fn));
    checkOutput({tag, ".hash_count"}, 640'(hash_count_w[d]), 640'(v.exp_cnt));
    checkOutput({tag, ".found_hash"}, 640'(found_hash_w[d]),
                v.exp_hit ? 640'({~v.exp_fn, 480'h0}) : 640'(0));
    checkOutput({tag, ".done_pulses"}, 640'(mon_done), 640'(1));
    checkOutput({tag, ".issued"}, 640'(issued_q.size()), 640'(v.exp_cnt));
    foreach (issued_q[i]) if (issued_q[i] !== v.ns + 32'(i)) bad++;
    checkOutput({tag, ".order"}, 640'(bad), 640'(0));
    checkOutput({tag, ".spacing"}, 640'(spacing_err), 640'(0));
    checkOutput({tag, ".din_stable"}, 640'(stab_err), 640'(0));
    checkOutput({tag, ".header"}, 640'(hdr_err), 640'(0));
  endtask

  initial begin
    vec_t tbl[10];
    int guard;

    rstb = 1'b0; start_w = '0; stop_w = '0; act = 1'b0;
    header = '0; nonce_start = '0; nonce_end = '0; target = '0;
    mon_last_ena = -1; mon_done = 0; spacing_err = 0; stab_err = 0; hdr_err = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst.ctrl", 640'({core_ena_w[d], busy_w[d], done_w[d], hit_w[d], aborted_w[d]}), 640'(0));
      checkOutput("rst.found_nonce", 640'(found_nonce_w[d]), 640'(0));
      checkOutput("rst.found_hash", 640'(found_hash_w[d]), 640'(0));
      checkOutput("rst.hash_count", 640'(hash_count_w[d]), 640'(0));
      checkOutput("rst.core_din", core_din_w[d], 640'(0));
    end
    rstb = 1'b1;

    tbl[0] = mk(0, 32'h10, 32'h1F, 64'hFFFFFFE8_00000000, 0, 0, 0, 0, 1, 32'h17, 33'd8, 0);
    tbl[1] = mk(0, 32'h10, 32'h1F, 64'h0, 0, 0, 0, 0, 0, 32'h0, 33'd16, 0);
    tbl[2] = mk(1, 32'hFFFFFFFE, 32'h1, 64'h0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 33'd4, 0);
    tbl[3] = mk(0, 32'h10, 32'h1F, 64'h0, 3, 2, 0, 0, 0, 32'h0, 33'd3, 1);
    tbl[4] = mk(0, 32'h10, 32'h1F, 64'hFFFFFFE8_00000000, 8, 6, 0, 0, 1, 32'h17, 33'd8, 0);
    tbl[5] = mk(1, 32'h10, 32'h1F, 64'hFFFFFFE8_00000000, 0, 0, 0, 0, 1, 32'h17, 33'd16, 0);
    tbl[6] = mk(0, 32'h55, 32'h55, 64'h0, 0, 0, 0, 0, 0, 32'h0, 33'd1, 0);
    tbl[7] = mk(0, 32'h20, 32'h2F, 64'h0, 0, 0, 1, 1, 0, 32'h0, 33'd16, 0);
    tbl[8] = mk(1, 32'h10, 32'h1F, 64'h0, 2, 1, 0, 0, 0, 32'h0, 33'd2, 1);
    tbl[9] = mk(0, 32'hFFFFFFFE, 32'h1, 64'h0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 33'd2, 0);
    for (int i = 0; i < 10; i++) run_and_check(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted in WAIT of the tenth hash after a hit was already recorded.
    @(negedge clk);
    act = 1'b1;
    issued_q.delete(); mon_done = 0; mon_last_ena = -1;
    nonce_start = 32'h10; nonce_end = 32'h1F; target = 64'hFFFFFFE8_00000000;
    start_w[1] = 1'b1;
    @(negedge clk);
    start_w[1] = 1'b0;
    guard = 0;
    while (hash_count_w[1] != 33'd9 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rstmid.reach", 640'(guard < 200), 640'(1));
    checkOutput("rstmid.pre_hit", 640'(hit_w[1]), 640'(1));
    repeat (3) @(negedge clk);
    rstb = 1'b0;
    #1;
    checkOutput("rstmid.ctrl", 640'({core_ena_w[1], busy_w[1], done_w[1], hit_w[1], aborted_w[1]}), 640'(0));
    checkOutput("rstmid.found_nonce", 640'(found_nonce_w[1]), 640'(0));
    checkOutput("rstmid.found_hash", 640'(found_hash_w[1]), 640'(0));
    checkOutput("rstmid.hash_count", 640'(hash_count_w[1]), 640'(0));
    checkOutput("rstmid.core_din", core_din_w[1], 640'(0));
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("rstmid.no_done", 640'(mon_done), 640'(0));
    checkOutput("rstmid.idle", 640'({busy_w[1], core_ena_w[1]}), 640'(0));

    for (int j = 0; j < 24; j++) begin
      vec_t v;
      int len;
      logic [31:0] k;
      v.dut = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 20);
      v.ns = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : 32'($urandom);
      v.ne = v.ns + 32'(len - 1);
      k = v.ns + 32'($urandom_range(0, len + 3));
      case ($urandom_range(0, 2))
        0:       v.tgt = 64'h0;
        1:       v.tgt = {~k, 32'($urandom)};
        default: v.tgt = {32'($urandom), 32'($urandom)};
      endcase
      v.stop_hash  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len + 1) : 0;
      v.stop_cyc   = $urandom_range(1, 6);
      v.start_stop = 1'($urandom_range(0, 1));
      v.poke_start = ($urandom_range(0, 3) == 0);
      v = ref_model(v);
      run_and_check(v, $sformatf("rnd%0d", j));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/blake_nonce_sched.md
# blake_nonce_sched

Nonce-sweep scheduler that sequences one `blake` core. It latches an 80-byte header template, a nonce range and a 64-bit target. It then issues one hash per nonce to the core, compares each digest against the target and reports the first hit or range exhaustion. It sits between the host/job interface and the `blake` core. It is the only driver of the core's `ena` and `din`.

## Interface
Parameters:
- `STOP_ON_HIT`, 1: 1 = finish at first hit; 0 = record the first hit and keep sweeping to `nonce_end`.

Ports:
- `clk` in 1: single clock.
- `rstb` in 1: asynchronous, active-low reset.
- `start` in 1: job start pulse. Sampled only in IDLE.
- `stop` in 1: abort request. Sampled only while busy.
- `header` in 608: header bytes 0..75. Maps to `core_din[639:32]`.
- `nonce_start` in 32: first nonce.
- `nonce_end` in 32: last nonce, inclusive.
- `target` in 64: a digest is a hit when `core_dout[511:448]` ≤ `target` (unsigned).
- `core_ena` out 1: single-cycle launch pulse to the core.
- `core_din` out 640: `{hdr_q, nonce_q}`. Held stable from `core_ena` through `core_rdy` inclusive.
- `core_dout` in 512: core digest. Valid only when `core_rdy`=1.
- `core_rdy` in 1: core completion pulse.
- `busy` out 1: a job is active, including drain.
- `done` out 1: one-cycle pulse at job end.
- `hit` out 1: a hit was found in the current or last job.
- `aborted` out 1: the last job ended via `stop`.
- `found_nonce` out 32: nonce of the first hit.
- `found_hash` out 512: digest of the first hit.
- `hash_count` out 33: number of hashes evaluated in the current or last job.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- IDLE:
  - On `start`: latch `header`→`hdr_q`, `nonce_start`→`nonce_q`, `nonce_end`→`end_q`, `target`→`tgt_q`.
  - Clear `hit`, `aborted`, `found_*` and `hash_count`.
  - Go to ISSUE.
- ISSUE: assert `core_ena` for exactly one cycle, then go to WAIT.
- WAIT, on `core_rdy`:
  - Increment `hash_count`.
  - Compute `is_hit = core_dout[511:448] <= tgt_q`.
  - If `is_hit` and `hit`=0: set `hit`, latch `found_nonce`=`nonce_q` and `found_hash`=`core_dout`.
  - Evaluate `last = (nonce_q == end_q)`.
  - Go to DONE if any of these holds: `last`; `STOP_ON_HIT` and `is_hit`; `stop` sampled in this job.
  - Otherwise `nonce_q <= nonce_q + 1` (mod 2^32) and go to ISSUE.
- `stop` handling:
  - `stop` seen in ISSUE or WAIT sets an internal `stop_pend`.
  - The core cannot be aborted. The in-flight hash is always completed and evaluated, so a hit is never lost.
  - `aborted`=1 at DONE only if the job ended because of `stop_pend` and not because of `last` or a hit.
- DRAIN: not entered in normal operation. It is reserved for a `core_rdy` outstanding at `stop`. The implementation uses WAIT for this; DRAIN exists only as an encoding.
- DONE: pulse `done` for one cycle, then go to IDLE. `hit`, `aborted`, `found_*` and `hash_count` hold until the next accepted `start`.
- Range rules:
  - `nonce_end` < `nonce_start`: the sweep wraps 0xFFFFFFFF→0x00000000.
  - `nonce_end` == `nonce_start`: exactly one hash.
  - `nonce_end` == `nonce_start`−1: full 2^32 sweep, `hash_count` = 0x1_0000_0000.
- Ignored inputs:
  - `start` while busy is ignored.
  - `stop` in IDLE is ignored.
  - `start` and `stop` in the same IDLE cycle: start is accepted, stop is dropped.
- `core_rdy` outside WAIT is ignored.

## Timing
- Reset (`rstb`=0, async): state=IDLE. `core_ena`, `busy`, `done`, `hit`, `aborted` = 0. `found_nonce`, `found_hash`, `hash_count`, `hdr_q`, `nonce_q` = 0. `core_din` = 0.
- Reset mid-job: the job is discarded with no `done`. The core is reset by the same `rstb`.
- Core latency L = cycles from `core_ena` to `core_rdy`.
- `start` sampled at edge T: `busy`=1 and `core_ena`=1 in cycle T+1.
- Consecutive `core_ena` pulses are L+1 cycles apart: `core_rdy` at cycle c is followed by `core_ena` at c+1.
- `found_*`, `hit` and `hash_count` update at the edge where `core_rdy` is sampled.
- `done`=1 in the cycle after the final `core_rdy`. `busy` falls in the cycle after `done`.
- All outputs are registered. No combinational path from `core_dout` to any output.

## Test plan
Test core: fixed L=5, returns `core_dout[511:448]` = `{~nonce, 32'h0}`, all other digest bits 0.

1. Basic hit: `nonce_start`=0x10, `nonce_end`=0x1F, `target`=0xFFFFFFE8_00000000, STOP_ON_HIT=1 → `hit`=1, `found_nonce`=0x17, `hash_count`=8, `done` one cycle, `aborted`=0. Six-cycle `core_ena` spacing; `core_din[31:0]` stable through each `core_rdy`.
2. Exhaustion: same range, `target`=0 → `hit`=0, `hash_count`=16, last `core_din[31:0]`=0x1F.
3. Wrap-around: `nonce_start`=0xFFFFFFFE, `nonce_end`=0x00000001, `target`=0 → nonces issued in order FFFFFFFE, FFFFFFFF, 0, 1; `hash_count`=4.
4. Stop mid-hash: `stop` in cycle 2 of the third hash → that hash completes, `hash_count`=3, `aborted`=1, `done` pulses, no further `core_ena`. Repeat with `stop` coinciding with a hit `core_rdy` → `hit`=1, `aborted`=0.
5. STOP_ON_HIT=0, range 0x10..0x1F, `target`=0xFFFFFFE8_00000000 → `found_nonce`=0x17 (first hit retained), `hash_count`=16.
6. Async reset asserted in WAIT → all outputs 0 immediately, no `done`. `start` during busy ignored; `start`+`stop` same IDLE cycle → job starts.
